// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one bme280_i2c_ctrl byte-command port between
// NREQ requesters; grant is held for a whole transfer, with a watchdog release.
module i2c_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NREQ-1:0]   Req,
  input  logic [NREQ-1:0]   Start,
  input  logic [NREQ-1:0]   Rdwr,
  input  logic [NREQ-1:0]   Last,
  input  logic [8*NREQ-1:0] Addr,
  input  logic [8*NREQ-1:0] Txd,
  output logic [NREQ-1:0]   Gnt,
  output logic [NREQ-1:0]   Done,
  output logic [NREQ-1:0]   Err,
  output logic [7:0]        Rxd,
  output logic              Busy,
  output logic              I2CC_start,
  output logic              I2CC_rdwr,
  output logic              I2CC_last,
  output logic [7:0]        I2CC_addr,
  output logic [7:0]        I2CC_txd,
  input  logic [7:0]        I2CC_rxd,
  input  logic              I2CC_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, own_q, own_d, nxt_ptr;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [7:0]      rxd_q, rxd_d, addr_q, addr_d, txd_q, txd_d;
  logic            start_q, start_d, rdwr_q, rdwr_d, last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            pick_vld;
  logic [PW-1:0]   pick, cand;
  logic            own_start, own_req, own_rdwr, own_last;
  logic [7:0]      own_addr, own_txd;

  // First set request at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = PW'((32'(ptr_q) + i) % NREQ);
      if (!pick_vld && Req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    own_start = 1'b0;
    own_req   = 1'b0;
    own_rdwr  = 1'b0;
    own_last  = 1'b0;
    own_addr  = '0;
    own_txd   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (own_q == PW'(i)) begin
        own_start = Start[i];
        own_req   = Req[i];
        own_rdwr  = Rdwr[i];
        own_last  = Last[i];
        own_addr  = Addr[8*i +: 8];
        own_txd   = Txd[8*i +: 8];
      end
    end
  end

  assign nxt_ptr = (own_q == PW'(NREQ-1)) ? '0 : own_q + PW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    rxd_d   = rxd_q;
    start_d = 1'b0;
    rdwr_d  = rdwr_q;
    last_d  = last_q;
    addr_d  = addr_q;
    txd_d   = txd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          own_d   = pick;
          gnt_d   = NREQ'(1) << pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (own_start) begin
          rdwr_d  = own_rdwr;
          last_d  = own_last;
          addr_d  = own_addr;
          txd_d   = own_txd;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = XFER;
        end else if (!own_req) begin
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end
      end
      XFER: begin
        // A completion in the watchdog's final cycle still counts as success.
        if (I2CC_done) begin
          done_d = gnt_q;
          rxd_d  = I2CC_rxd;
          if (last_q || !own_req) begin
            gnt_d   = '0;
            ptr_d   = nxt_ptr;
            state_d = IDLE;
          end else begin
            state_d = GRANT;
          end
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rxd_q   <= '0;
      start_q <= 1'b0;
      rdwr_q  <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      txd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rxd_q   <= rxd_d;
      start_q <= start_d;
      rdwr_q  <= rdwr_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      txd_q   <= txd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Gnt        = gnt_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign Rxd        = rxd_q;
  assign Busy       = |gnt_q;
  assign I2CC_start = start_q;
  assign I2CC_rdwr  = rdwr_q;
  assign I2CC_last  = last_q;
  assign I2CC_addr  = addr_q;
  assign I2CC_txd   = txd_q;

endmodule
